fast_window_scheduler: RTL and testbench

- Raster-scan controller that sequences the FAST 7x7 window datapath: line buffers, the window shift register and the circle sampler.
- Counts incoming pixel columns and rows for one frame. Drives line-buffer write/address and window shift strobes.
- Asserts window_valid only when a full 7x7 neighbourhood exists, suppressing the 3-pixel border.
- Reports the window centre coordinate and frame start/done/error status to the feature-extractor top.

---
 rtl/fast_window_scheduler.sv | 140 ++++++++++++++
 tb/tb_fast_window_scheduler.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_window_scheduler.sv
// Raster-scan scheduler for the FAST 7x7 window datapath: counts pixels, drives
// line-buffer/window strobes and flags windows whose full neighbourhood is present.
module fast_window_scheduler #(
  parameter int unsigned MAX_WIDTH  = 640,
  parameter int unsigned MAX_HEIGHT = 480,
  parameter int unsigned COL_W      = $clog2(MAX_WIDTH + 1),
  parameter int unsigned ROW_W      = $clog2(MAX_HEIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [COL_W-1:0] cfg_width,
  input  logic [ROW_W-1:0] cfg_height,
  input  logic             frame_start,
  input  logic             frame_abort,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             dn_stall,
  output logic             lb_wr_en,
  output logic [COL_W-1:0] lb_addr,
  output logic             win_shift_en,
  output logic             window_valid,
  output logic [COL_W-1:0] win_x,
  output logic [ROW_W-1:0] win_y,
  output logic             frame_busy,
  output logic             frame_done,
  output logic             cfg_err
);

  localparam logic [COL_W-1:0] MIN_COLS = COL_W'(7);
  localparam logic [ROW_W-1:0] MIN_ROWS = ROW_W'(7);
  localparam logic [COL_W-1:0] MAX_COLS = COL_W'(MAX_WIDTH);
  localparam logic [ROW_W-1:0] MAX_ROWS = ROW_W'(MAX_HEIGHT);
  localparam logic [COL_W-1:0] EDGE_COL = COL_W'(6);
  localparam logic [ROW_W-1:0] EDGE_ROW = ROW_W'(6);
  localparam logic [COL_W-1:0] HALF_COL = COL_W'(3);
  localparam logic [ROW_W-1:0] HALF_ROW = ROW_W'(3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] width_q;
  logic [ROW_W-1:0] height_q;

  logic             accept;
  logic             cfg_legal;
  logic             col_last;
  logic             row_last;
  logic             win_hit;

  // Abort takes priority over a pixel offered in the same cycle.
  assign pix_ready    = (state == RUN) & ~dn_stall & ~frame_abort;
  assign accept       = pix_valid & pix_ready;
  assign lb_wr_en     = accept;
  assign win_shift_en = accept;
  assign lb_addr      = col;

  assign cfg_legal = (cfg_width  >= MIN_COLS) && (cfg_width  <= MAX_COLS) &&
                     (cfg_height >= MIN_ROWS) && (cfg_height <= MAX_ROWS);
  assign col_last  = (col == COL_W'(width_q  - COL_W'(1)));
  assign row_last  = (row == ROW_W'(height_q - ROW_W'(1)));
  assign win_hit   = (col >= EDGE_COL) && (row >= EDGE_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      width_q      <= '0;
      height_q     <= '0;
      window_valid <= 1'b0;
      win_x        <= '0;
      win_y        <= '0;
      frame_busy   <= 1'b0;
      frame_done   <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      cfg_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            if (cfg_legal) begin
              width_q    <= cfg_width;
              height_q   <= cfg_height;
              col        <= '0;
              row        <= '0;
              frame_busy <= 1'b1;
              state      <= RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (frame_abort) begin
            col        <= '0;
            row        <= '0;
            frame_busy <= 1'b0;
            state      <= IDLE;
          end else if (accept) begin
            // Centre of the 7x7 window lags the newest pixel by three in each axis.
            if (win_hit) begin
              window_valid <= 1'b1;
              win_x        <= COL_W'(col - HALF_COL);
              win_y        <= ROW_W'(row - HALF_ROW);
            end
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                row        <= '0;
                frame_busy <= 1'b0;
                frame_done <= 1'b1;
                state      <= DONE;
              end else begin
                row <= ROW_W'(row + ROW_W'(1));
              end
            end else begin
              col <= COL_W'(col + COL_W'(1));
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          frame_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fast_window_scheduler.sv
// Bench for fast_window_scheduler: randomized pixel/stall traffic against a
// pixel-index reference model (col = k % width, row = k / width).
module tb_fast_window_scheduler;
  localparam int unsigned MAX_WIDTH  = 640;
  localparam int unsigned MAX_HEIGHT = 480;
  localparam int unsigned COL_W      = 10;
  localparam int unsigned ROW_W      = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [COL_W-1:0] cfg_width = '0;
  logic [ROW_W-1:0] cfg_height = '0;
  logic             frame_start = 1'b0;
  logic             frame_abort = 1'b0;
  logic             pix_valid = 1'b0;
  logic             pix_ready;
  logic             dn_stall = 1'b0;
  logic             lb_wr_en;
  logic [COL_W-1:0] lb_addr;
  logic             win_shift_en;
  logic             window_valid;
  logic [COL_W-1:0] win_x;
  logic [ROW_W-1:0] win_y;
  logic             frame_busy;
  logic             frame_done;
  logic             cfg_err;

  fast_window_scheduler #(
    .MAX_WIDTH (MAX_WIDTH),
    .MAX_HEIGHT(MAX_HEIGHT),
    .COL_W     (COL_W),
    .ROW_W     (ROW_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .frame_start (frame_start),
    .frame_abort (frame_abort),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .dn_stall    (dn_stall),
    .lb_wr_en    (lb_wr_en),
    .lb_addr     (lb_addr),
    .win_shift_en(win_shift_en),
    .window_valid(window_valid),
    .win_x       (win_x),
    .win_y       (win_y),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: running flag, accepted-pixel index and frame geometry.
  bit m_run, m_in_done;
  int m_k, m_w, m_h, m_lx, m_ly;

  int    comb_bad, reg_bad, done_cnt, err_cnt, acc_cnt, strobe_cnt;
  string first_bad;
  int    wq_x[$];
  int    wq_y[$];

  task automatic clr_stats();
    comb_bad = 0; reg_bad = 0; done_cnt = 0; err_cnt = 0; acc_cnt = 0; strobe_cnt = 0;
    first_bad = "none";
    wq_x.delete(); wq_y.delete();
  endtask

  task automatic model_reset();
    m_run = 0; m_in_done = 0; m_k = 0; m_w = 0; m_h = 0; m_lx = 0; m_ly = 0;
  endtask

  // One clock cycle: drive at negedge, compare outputs against the model, advance it.
  task automatic step(input bit fs, input bit fa, input bit pv, input bit st);
    bit e_rdy, e_acc, e_wv, e_done, e_err, e_busy;
    int e_addr, c, r;
    frame_start = fs; frame_abort = fa; pix_valid = pv; dn_stall = st;
    #1;
    e_rdy  = m_run && !st && !fa;
    e_acc  = e_rdy && pv;
    e_addr = m_run ? (m_k % m_w) : 0;
    if (pix_ready !== e_rdy || lb_wr_en !== e_acc || win_shift_en !== e_acc ||
        lb_addr !== COL_W'(e_addr)) begin
      if (comb_bad == 0)
        first_bad = $sformatf("t=%0t ready=%b want %b wr=%b shift=%b want %b addr=%0d want %0d",
                              $time, pix_ready, e_rdy, lb_wr_en, win_shift_en, e_acc, lb_addr, e_addr);
      comb_bad++;
    end
    if (lb_wr_en === 1'b1) strobe_cnt++;
    e_wv = 0; e_done = 0; e_err = 0;
    if (m_in_done) begin
      m_in_done = 0;
    end else if (!m_run) begin
      if (fs) begin
        if (cfg_width >= 7 && cfg_width <= MAX_WIDTH && cfg_height >= 7 && cfg_height <= MAX_HEIGHT) begin
          m_run = 1; m_k = 0; m_w = int'(cfg_width); m_h = int'(cfg_height);
        end else begin
          e_err = 1;
        end
      end
    end else if (fa) begin
      m_run = 0;
    end else if (e_acc) begin
      c = m_k % m_w;
      r = m_k / m_w;
      acc_cnt++;
      if (c >= 6 && r >= 6) begin
        e_wv = 1; m_lx = c - 3; m_ly = r - 3;
      end
      m_k++;
      if (m_k == m_w * m_h) begin
        m_run = 0; m_in_done = 1; e_done = 1;
      end
    end
    e_busy = m_run;
    @(posedge clk);
    #1;
    if (window_valid !== e_wv || win_x !== COL_W'(m_lx) || win_y !== ROW_W'(m_ly) ||
        frame_busy !== e_busy || frame_done !== e_done || cfg_err !== e_err) begin
      if (reg_bad == 0)
        first_bad = $sformatf("t=%0t wv=%b want %b x=%0d want %0d y=%0d want %0d busy=%b want %b done=%b want %b err=%b want %b",
                              $time, window_valid, e_wv, win_x, m_lx, win_y, m_ly,
                              frame_busy, e_busy, frame_done, e_done, cfg_err, e_err);
      reg_bad++;
    end
    if (window_valid === 1'b1) begin
      wq_x.push_back(int'(win_x)); wq_y.push_back(int'(win_y));
    end
    if (frame_done === 1'b1) done_cnt++;
    if (cfg_err === 1'b1) err_cnt++;
    @(negedge clk);
  endtask

  task automatic start_frame(input int w, input int h);
    cfg_width  = COL_W'(w);
    cfg_height = ROW_W'(h);
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_frame(input int pv_pct, input int st_pct, input int fs_pct, input int budget);
    int n = 0;
    while (m_run && n < budget) begin
      step(($urandom_range(99) < fs_pct), 1'b0, ($urandom_range(99) < pv_pct),
           ($urandom_range(99) < st_pct));
      n++;
    end
  endtask

  // Mismatched entries between observed windows and the raster-order expectation.
  function automatic int win_diff(input int w, input int h);
    int n = 0;
    int bad = 0;
    for (int y = 3; y <= h - 4; y++)
      for (int x = 3; x <= w - 4; x++) begin
        if (n >= wq_x.size() || wq_x[n] != x || wq_y[n] != y) bad++;
        n++;
      end
    if (wq_x.size() != n) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    logic [15:0] outs;
    #1;
    outs = {4'd0, window_valid, win_x[0], win_y[0], frame_busy, frame_done, cfg_err,
            pix_ready, lb_wr_en, win_shift_en, lb_addr[0], 2'd0};
    checks++;
    if (outs !== 16'd0) $display("FAIL reset_outputs: got %h want 0000", outs);
    else passes++;
    checks++;
    if (win_x !== '0 || win_y !== '0 || lb_addr !== '0)
      $display("FAIL reset_coords: got x=%0d y=%0d addr=%0d want 0 0 0", win_x, win_y, lb_addr);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    clr_stats();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (strobe_cnt !== 0) $display("FAIL reset_idle_strobe: got %0d strobes want 0", strobe_cnt);
    else passes++;
  endtask

  task automatic test_basic_8x8();
    clr_stats();
    start_frame(8, 8);
    run_frame(100, 0, 0, 200);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (comb_bad !== 0 || reg_bad !== 0)
      $display("FAIL basic_cycle: comb=%0d reg=%0d bad cycles want 0 (%s)", comb_bad, reg_bad, first_bad);
    else passes++;
    checks++;
    if (acc_cnt !== 64) $display("FAIL basic_accepts: got %0d want 64", acc_cnt);
    else passes++;
    checks++;
    if (win_diff(8, 8) !== 0)
      $display("FAIL basic_windows: got %0d windows, %0d mismatches want 4 and 0", wq_x.size(), win_diff(8, 8));
    else passes++;
    checks++;
    if (done_cnt !== 1) $display("FAIL basic_done: got %0d want 1", done_cnt);
    else passes++;
  endtask

  task automatic test_cfg_err();
    int ws[4] = '{6, MAX_WIDTH + 1, 10, 10};
    int hs[4] = '{10, 10, 6, MAX_HEIGHT + 1};
    for (int i = 0; i < 4; i++) begin
      clr_stats();
      start_frame(ws[i], hs[i]);
      for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (err_cnt !== 1 || strobe_cnt !== 0 || frame_busy !== 1'b0)
        $display("FAIL cfg_err_%0dx%0d: err=%0d strobes=%0d busy=%b want 1 0 0",
                 ws[i], hs[i], err_cnt, strobe_cnt, frame_busy);
      else passes++;
      checks++;
      if (comb_bad !== 0 || reg_bad !== 0)
        $display("FAIL cfg_err_cycle: comb=%0d reg=%0d want 0 (%s)", comb_bad, reg_bad, first_bad);
      else passes++;
    end
  endtask

  task automatic test_stall();
    clr_stats();
    start_frame(10, 7);
    while (m_run && m_k < 64) step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (lb_addr !== COL_W'(4) || acc_cnt !== 64)
      $display("FAIL stall_frozen: addr=%0d accepts=%0d want 4 64", lb_addr, acc_cnt);
    else passes++;
    run_frame(100, 0, 0, 100);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (win_diff(10, 7) !== 0 || acc_cnt !== 70 || done_cnt !== 1)
      $display("FAIL stall_resume: windows=%0d accepts=%0d done=%0d want 4 70 1",
               wq_x.size(), acc_cnt, done_cnt);
    else passes++;
    checks++;
    if (comb_bad !== 0 || reg_bad !== 0)
      $display("FAIL stall_cycle: comb=%0d reg=%0d want 0 (%s)", comb_bad, reg_bad, first_bad);
    else passes++;
  endtask

  task automatic test_abort();
    clr_stats();
    start_frame(8, 8);
    while (m_run && m_k < 29) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (acc_cnt !== 29 || done_cnt !== 0 || frame_busy !== 1'b0)
      $display("FAIL abort_stop: accepts=%0d done=%0d busy=%b want 29 0 0", acc_cnt, done_cnt, frame_busy);
    else passes++;
    clr_stats();
    start_frame(8, 8);
    run_frame(100, 0, 0, 200);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (win_diff(8, 8) !== 0 || done_cnt !== 1)
      $display("FAIL abort_next_frame: windows=%0d done=%0d want 4 1", wq_x.size(), done_cnt);
    else passes++;
    checks++;
    if (comb_bad !== 0 || reg_bad !== 0)
      $display("FAIL abort_cycle: comb=%0d reg=%0d want 0 (%s)", comb_bad, reg_bad, first_bad);
    else passes++;
  endtask

  task automatic test_mid_reset();
    clr_stats();
    start_frame(8, 8);
    while (m_run && m_k < 59) step(1'b0, 1'b0, 1'b1, 1'b0);
    pix_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (window_valid !== 1'b0 || win_x !== '0 || win_y !== '0 || frame_busy !== 1'b0 ||
        frame_done !== 1'b0 || cfg_err !== 1'b0 || pix_ready !== 1'b0)
      $display("FAIL midreset_outputs: wv=%b x=%0d y=%0d busy=%b done=%b err=%b rdy=%b want all 0",
               window_valid, win_x, win_y, frame_busy, frame_done, cfg_err, pix_ready);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (done_cnt !== 0) $display("FAIL midreset_no_done: got %0d want 0", done_cnt);
    else passes++;
    clr_stats();
    start_frame(8, 8);
    run_frame(80, 20, 0, 400);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (win_diff(8, 8) !== 0 || done_cnt !== 1 || comb_bad !== 0 || reg_bad !== 0)
      $display("FAIL midreset_restart: windows=%0d done=%0d comb=%0d reg=%0d want 4 1 0 0 (%s)",
               wq_x.size(), done_cnt, comb_bad, reg_bad, first_bad);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    clr_stats();
    start_frame(7, 7);
    run_frame(100, 0, 0, 100);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (frame_busy !== 1'b0) $display("FAIL b2b_done_start_ignored: busy=%b want 0", frame_busy);
    else passes++;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (frame_busy !== 1'b1) $display("FAIL b2b_idle_start: busy=%b want 1", frame_busy);
    else passes++;
    run_frame(100, 0, 0, 100);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < wq_x.size(); i++) if (wq_x[i] != 3 || wq_y[i] != 3) bad++;
    checks++;
    if (wq_x.size() !== 2 || bad !== 0 || done_cnt !== 2)
      $display("FAIL b2b_results: windows=%0d off=%0d done=%0d want 2 0 2", wq_x.size(), bad, done_cnt);
    else passes++;
    checks++;
    if (comb_bad !== 0 || reg_bad !== 0)
      $display("FAIL b2b_cycle: comb=%0d reg=%0d want 0 (%s)", comb_bad, reg_bad, first_bad);
    else passes++;
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      int w = $urandom_range(20, 7);
      int h = $urandom_range(12, 7);
      clr_stats();
      start_frame(w, h);
      run_frame(75, 25, 10, 3000);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (m_run) $display("FAIL random_timeout: frame %0dx%0d still running at k=%0d want done", w, h, m_k);
      else passes++;
      checks++;
      if (win_diff(w, h) !== 0 || done_cnt !== 1 || comb_bad !== 0 || reg_bad !== 0)
        $display("FAIL random_%0dx%0d: windows=%0d want %0d done=%0d comb=%0d reg=%0d (%s)",
                 w, h, wq_x.size(), (w - 6) * (h - 6), done_cnt, comb_bad, reg_bad, first_bad);
      else passes++;
    end
  endtask

  task automatic test_max_width();
    clr_stats();
    start_frame(MAX_WIDTH, 7);
    run_frame(100, 0, 0, 5000);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (win_diff(MAX_WIDTH, 7) !== 0 || done_cnt !== 1 || comb_bad !== 0 || reg_bad !== 0)
      $display("FAIL max_width: windows=%0d want %0d done=%0d comb=%0d reg=%0d (%s)",
               wq_x.size(), MAX_WIDTH - 6, done_cnt, comb_bad, reg_bad, first_bad);
    else passes++;
  endtask

  initial begin
    model_reset();
    clr_stats();
    #22;
    test_reset();
    test_basic_8x8();
    test_cfg_err();
    test_stall();
    test_abort();
    test_mid_reset();
    test_back_to_back();
    test_random();
    test_max_width();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
